breakpoint_unit: RTL and testbench
==================================

Name: breakpoint_unit

Overview:
- Multi-channel, width-parametrised breakpoint unit for the GB80 CPU debug path.
- Holds NUM_BP breakpoint addresses, each with its own enable. Addresses are entered one byte at a time from the 8-bit switch bank, and the selected byte is shown on the 7-seg display.
- Compares enabled channels against the CPU instruction-fetch address and raises a registered halt request.
- Halt and resume use a handshake with a one-fetch skip, so the CPU can step past the breakpointed instruction.

Parameters:
- ADDR_WIDTH, 16, breakpoint/CPU address width. Must be a multiple of 8, at least 8.
- NUM_BP, 4, number of breakpoint channels. Range 1..16.
- RESET_ADDR, {ADDR_WIDTH{1'b1}}, reset value of every channel address.
- (derived localparams) NUM_BYTES = ADDR_WIDTH/8; SEL_W = max(1, clog2(NUM_BP)); BYTE_W = max(1, clog2(NUM_BYTES)).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_part_in  in  8  byte value to write.
- cfg_sel_in  in  SEL_W  channel selected for write, enable toggle and display.
- cfg_byte_next_in  in  1  advance byte pointer, one per asserted cycle.
- cfg_write_in  in  1  write cfg_part_in into the selected byte of the selected channel.
- cfg_en_toggle_in  in  1  invert the enable of the selected channel.
- cfg_disp  out  8  byte[byte_ptr] of channel cfg_sel_in (combinational).
- cfg_byte_ptr  out  BYTE_W  current byte pointer (0 = LSB).
- bp_enable  out  NUM_BP  per-channel enable flags.
- cpu_addr  in  ADDR_WIDTH  CPU fetch address.
- cpu_fetch  in  1  one-cycle strobe per instruction fetch.
- resume_in  in  1  single-cycle resume pulse from the debug controller.
- halt_req  out  1  registered halt request to the CPU stall logic.
- hit_id  out  SEL_W  channel that caused the most recent halt.

Behaviour:
- Reset (reset_n low, asynchronous):
  - all channel addresses = RESET_ADDR, bp_enable = 0, byte_ptr = 0;
  - FSM = RUN, halt_req = 0, hit_id = 0;
  - reset mid-HALT or mid-SKIP returns to RUN with no pending halt.
- Byte pointer: cfg_byte_next_in increments byte_ptr modulo NUM_BYTES, wrapping from NUM_BYTES-1 to 0. The pointer is shared by all channels. For NUM_BYTES = 1 it stays 0.
- Write: cfg_write_in replaces byte[byte_ptr] of channel cfg_sel_in at the next edge; other bytes are unchanged.
  - Write and byte_next in the same cycle: the write uses the pre-increment pointer.
  - cfg_sel_in >= NUM_BP: write, toggle and display are ignored; cfg_disp = 8'h00.
- Enable: cfg_en_toggle_in flips bp_enable[cfg_sel_in]. Toggle and write in the same cycle both take effect.
- Config access is legal in every FSM state, with no effect on the current halt.
- Match (combinational):
  - hit_vec[i] = bp_enable[i] & (cpu_addr == addr[i]), qualified by cpu_fetch;
  - lowest index wins when several channels match.
- FSM (states RUN, HALT, SKIP):
  - RUN: on a qualified hit, go to HALT. halt_req = 1 from the edge after the fetch cycle (1-cycle latency). hit_id latches the winning index.
  - HALT: halt_req is held at 1 and hit_id is held. Fetches are ignored. On resume_in, go to SKIP with halt_req = 0 at the same edge. Disabling or rewriting the hit channel does not release the halt.
  - SKIP: the next cpu_fetch is never matched, then go to RUN. resume_in in SKIP or RUN is ignored. A fetch at the same edge as resume_in (HALT→SKIP) does not count as the skipped fetch.
- hit_id keeps its value until the next halt.

Decomposition:
- Package gb80_bp_pkg:
  - bp_state_t enum {BP_RUN, BP_HALT, BP_SKIP};
  - clog2-style helper function for SEL_W/BYTE_W.
- Sub-module bp_channel, instantiated NUM_BP times via generate. It holds one address register and one enable flag, does the byte-lane write and toggle, and outputs match and the display byte. The top level keeps byte_ptr, the priority encoder, the FSM, halt_req and hit_id.

Test Plan:
- Reset entry: drive reset_n = 0 mid-operation.
  - Required: halt_req = 0, bp_enable = 0, cfg_disp = 8'hFF, cfg_byte_ptr = 0 immediately, before any clock edge.
- Byte entry, ADDR_WIDTH = 16:
  - Stimulus: sel = 2; write 8'h34; byte_next; write 8'h12.
  - Required: cfg_disp = 8'h12. After one more byte_next the pointer wraps to 0 and cfg_disp = 8'h34. Channel 2 address = 16'h1234.
- Basic halt:
  - Stimulus: enable ch2 (16'h1234); fetch 16'h1233, then 16'h1234.
  - Required: halt_req = 1 exactly one cycle after the 16'h1234 fetch; hit_id = 2; later fetches have no effect.
- Priority and disabled channels:
  - Stimulus: ch1 and ch3 both = 16'h0100; only ch3 enabled; fetch 16'h0100.
  - Required: hit_id = 3.
  - Then enable ch1, resume, fetch 16'h0100 twice.
  - Required: the first fetch is skipped; the second halts with hit_id = 1.
- Resume/skip:
  - Stimulus: pulse resume_in while halted.
  - Required: halt_req = 0 next cycle; a fetch of the breakpoint address in SKIP gives no halt; the following fetch of the same address halts again.
- Simultaneous events:
  - Stimulus: cfg_write + cfg_byte_next + cfg_en_toggle in one cycle.
  - Required: old pointer byte written, pointer advanced, enable flipped.
  - Stimulus: cfg_sel_in = NUM_BP (out of range).
  - Required: no state change and cfg_disp = 8'h00. For this check, instantiate NUM_BP = 3 so the value is representable in SEL_W.

Source files
------------

// File: rtl/breakpoint_unit_pkg.sv
// Shared types and width helper for the GB80 breakpoint unit.
package gb80_bp_pkg;

  typedef enum logic [1:0] {
    BP_RUN  = 2'd0,
    BP_HALT = 2'd1,
    BP_SKIP = 2'd2
  } bp_state_t;

  // Ceiling log2, never less than 1 so select/pointer buses always exist.
  function automatic int bp_clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/breakpoint_unit_channel.sv
// One breakpoint channel: address register with byte-lane writes, enable flag,
// address compare and display-byte selection.
module bp_channel #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '1,
  parameter int                    BYTE_W     = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  sel,
  input  logic                  write,
  input  logic                  toggle,
  input  logic [7:0]            part,
  input  logic [BYTE_W-1:0]     byte_ptr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  enable,
  output logic                  match,
  output logic [7:0]            disp_byte
);

  localparam int NUM_BYTES = ADDR_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  enable_q;

  // Replace only the byte lane addressed by the shared pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= RESET_ADDR;
    end else if (sel && write) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (byte_ptr == BYTE_W'(b)) addr_q[b*8 +: 8] <= part;
      end
    end
  end

  // Enable flag flips on each toggle of this channel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) enable_q <= 1'b0;
    else if (sel && toggle) enable_q <= ~enable_q;
  end

  // Byte currently pointed at, for the 7-seg display.
  always_comb begin
    disp_byte = 8'h00;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (byte_ptr == BYTE_W'(b)) disp_byte = addr_q[b*8 +: 8];
    end
  end

  assign enable = enable_q;
  assign match  = enable_q && (cpu_addr == addr_q);

endmodule

// File: rtl/breakpoint_unit.sv
// GB80 breakpoint unit: NUM_BP channels, byte-wise config, halt/resume/skip FSM.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   BP_RUN  | watching fetches; a qualified hit halts the CPU
//   BP_HALT | halt_req held high, fetches ignored until resume_in
//   BP_SKIP | next fetch is stepped past unmatched, then back to RUN
module breakpoint_unit
  import gb80_bp_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    NUM_BP     = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = {ADDR_WIDTH{1'b1}},
  localparam int                   NUM_BYTES  = ADDR_WIDTH / 8,
  localparam int                   SEL_W      = bp_clog2(NUM_BP),
  localparam int                   BYTE_W     = bp_clog2(NUM_BYTES)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [7:0]            cfg_part_in,
  input  logic [SEL_W-1:0]      cfg_sel_in,
  input  logic                  cfg_byte_next_in,
  input  logic                  cfg_write_in,
  input  logic                  cfg_en_toggle_in,
  output logic [7:0]            cfg_disp,
  output logic [BYTE_W-1:0]     cfg_byte_ptr,
  output logic [NUM_BP-1:0]     bp_enable,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_fetch,
  input  logic                  resume_in,
  output logic                  halt_req,
  output logic [SEL_W-1:0]      hit_id
);

  logic [BYTE_W-1:0] byte_ptr_q;
  logic [NUM_BP-1:0] ch_sel;
  logic [NUM_BP-1:0] ch_match;
  logic [7:0]        ch_disp [NUM_BP];
  logic              hit_any;
  logic [SEL_W-1:0]  hit_idx;
  logic [SEL_W-1:0]  hit_id_q;
  bp_state_t         state_q, state_d;

  // Shared byte pointer, wraps at the top byte.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_ptr_q <= '0;
    end else if (cfg_byte_next_in) begin
      byte_ptr_q <= (byte_ptr_q == BYTE_W'(NUM_BYTES - 1)) ? '0 : byte_ptr_q + 1'b1;
    end
  end

  // Per-channel decode of the selector; out-of-range values select nothing.
  always_comb begin
    for (int i = 0; i < NUM_BP; i++) ch_sel[i] = (cfg_sel_in == SEL_W'(i));
  end

  for (genvar g = 0; g < NUM_BP; g++) begin : g_ch
    bp_channel #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_ADDR (RESET_ADDR),
      .BYTE_W     (BYTE_W)
    ) u_ch (
      .clock     (clock),
      .reset_n   (reset_n),
      .sel       (ch_sel[g]),
      .write     (cfg_write_in),
      .toggle    (cfg_en_toggle_in),
      .part      (cfg_part_in),
      .byte_ptr  (byte_ptr_q),
      .cpu_addr  (cpu_addr),
      .enable    (bp_enable[g]),
      .match     (ch_match[g]),
      .disp_byte (ch_disp[g])
    );
  end

  // Display mux; reads 8'h00 when no channel is selected.
  always_comb begin
    cfg_disp = 8'h00;
    for (int i = 0; i < NUM_BP; i++) begin
      if (ch_sel[i]) cfg_disp = ch_disp[i];
    end
  end

  // Fetch-qualified priority encoder, lowest index wins.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (cpu_fetch && ch_match[i]) begin
        hit_any = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= BP_RUN;
    else          state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BP_RUN:  if (hit_any)   state_d = BP_HALT;
      BP_HALT: if (resume_in) state_d = BP_SKIP;
      BP_SKIP: if (cpu_fetch) state_d = BP_RUN;
      default:                state_d = BP_RUN;
    endcase
  end

  // Winning channel is captured only when a halt is taken.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) hit_id_q <= '0;
    else if ((state_q == BP_RUN) && hit_any) hit_id_q <= hit_idx;
  end

  // FSM outputs, decoded from the registered state.
  always_comb begin
    halt_req = (state_q == BP_HALT);
  end

  assign hit_id       = hit_id_q;
  assign cfg_byte_ptr = byte_ptr_q;

endmodule

// File: tb/tb_breakpoint_unit.sv
// Self-checking bench for breakpoint_unit (NUM_BP=4 main instance, NUM_BP=3
// instance for out-of-range selector behaviour).
module tb_breakpoint_unit;

  typedef struct {
    bit          fetch;
    logic [15:0] addr;
    bit          resume;
    bit          exp_halt;
    logic [1:0]  exp_id;
  } row_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;

  logic [7:0]  cfg_part_in = '0;
  logic [1:0]  cfg_sel_in = '0;
  logic        cfg_byte_next_in = 1'b0;
  logic        cfg_write_in = 1'b0;
  logic        cfg_en_toggle_in = 1'b0;
  logic [7:0]  cfg_disp;
  logic [0:0]  cfg_byte_ptr;
  logic [3:0]  bp_enable;
  logic [15:0] cpu_addr = '0;
  logic        cpu_fetch = 1'b0;
  logic        resume_in = 1'b0;
  logic        halt_req;
  logic [1:0]  hit_id;

  logic [7:0]  c3_part = '0;
  logic [1:0]  c3_sel = '0;
  logic        c3_next = 1'b0;
  logic        c3_write = 1'b0;
  logic        c3_toggle = 1'b0;
  logic [7:0]  c3_disp;
  logic [0:0]  c3_ptr;
  logic [2:0]  c3_enable;
  logic        c3_halt;
  logic [1:0]  c3_hit_id;

  int n_pass  = 0;
  int n_total = 0;
  logic [2:0] exp_q[$];

  breakpoint_unit #(.ADDR_WIDTH(16), .NUM_BP(4)) u_dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .cfg_part_in      (cfg_part_in),
    .cfg_sel_in       (cfg_sel_in),
    .cfg_byte_next_in (cfg_byte_next_in),
    .cfg_write_in     (cfg_write_in),
    .cfg_en_toggle_in (cfg_en_toggle_in),
    .cfg_disp         (cfg_disp),
    .cfg_byte_ptr     (cfg_byte_ptr),
    .bp_enable        (bp_enable),
    .cpu_addr         (cpu_addr),
    .cpu_fetch        (cpu_fetch),
    .resume_in        (resume_in),
    .halt_req         (halt_req),
    .hit_id           (hit_id)
  );

  breakpoint_unit #(.ADDR_WIDTH(16), .NUM_BP(3)) u_dut3 (
    .clock            (clock),
    .reset_n          (reset_n),
    .cfg_part_in      (c3_part),
    .cfg_sel_in       (c3_sel),
    .cfg_byte_next_in (c3_next),
    .cfg_write_in     (c3_write),
    .cfg_en_toggle_in (c3_toggle),
    .cfg_disp         (c3_disp),
    .cfg_byte_ptr     (c3_ptr),
    .bp_enable        (c3_enable),
    .cpu_addr         (16'h0000),
    .cpu_fetch        (1'b0),
    .resume_in        (1'b0),
    .halt_req         (c3_halt),
    .hit_id           (c3_hit_id)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_wr(input logic [1:0] sel, input logic [7:0] val);
    cfg_sel_in = sel; cfg_part_in = val; cfg_write_in = 1'b1;
    cyc();
    cfg_write_in = 1'b0;
  endtask

  task automatic cfg_next();
    cfg_byte_next_in = 1'b1;
    cyc();
    cfg_byte_next_in = 1'b0;
  endtask

  task automatic cfg_tog(input logic [1:0] sel);
    cfg_sel_in = sel; cfg_en_toggle_in = 1'b1;
    cyc();
    cfg_en_toggle_in = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    n_total++;
    if (halt_req !== 1'b0) $display("FAIL reset_halt: got %b expected 0", halt_req); else n_pass++;
    n_total++;
    if (bp_enable !== 4'b0000) $display("FAIL reset_enable: got %b expected 0000", bp_enable); else n_pass++;
    n_total++;
    if (cfg_disp !== 8'hFF) $display("FAIL reset_disp: got %h expected ff", cfg_disp); else n_pass++;
    n_total++;
    if (cfg_byte_ptr !== 1'b0) $display("FAIL reset_ptr: got %0d expected 0", cfg_byte_ptr); else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_byte_entry();
    cfg_wr(2'd2, 8'h34);
    cfg_next();
    cfg_wr(2'd2, 8'h12);
    n_total++;
    if (cfg_disp !== 8'h12) $display("FAIL entry_hi_disp: got %h expected 12", cfg_disp); else n_pass++;
    n_total++;
    if (cfg_byte_ptr !== 1'b1) $display("FAIL entry_ptr1: got %0d expected 1", cfg_byte_ptr); else n_pass++;
    cfg_next();
    n_total++;
    if (cfg_byte_ptr !== 1'b0) $display("FAIL entry_wrap: got %0d expected 0", cfg_byte_ptr); else n_pass++;
    n_total++;
    if (cfg_disp !== 8'h34) $display("FAIL entry_lo_disp: got %h expected 34", cfg_disp); else n_pass++;
    cfg_sel_in = 2'd0;
    #1;
    n_total++;
    if (cfg_disp !== 8'hFF) $display("FAIL entry_other_ch: got %h expected ff", cfg_disp); else n_pass++;
  endtask

  task automatic test_basic_halt();
    row_t rows[$];
    logic [2:0] e;
    cfg_tog(2'd2);
    n_total++;
    if (bp_enable !== 4'b0100) $display("FAIL halt_enable: got %b expected 0100", bp_enable); else n_pass++;
    rows.push_back('{0, 16'h1234, 0, 0, 2'd0});
    rows.push_back('{1, 16'h1233, 0, 0, 2'd0});
    rows.push_back('{1, 16'h1234, 0, 1, 2'd2});
    rows.push_back('{1, 16'h0000, 0, 1, 2'd2});
    rows.push_back('{1, 16'h1234, 0, 1, 2'd2});
    rows.push_back('{0, 16'h0000, 0, 1, 2'd2});
    foreach (rows[i]) begin
      cpu_fetch = rows[i].fetch; cpu_addr = rows[i].addr; resume_in = rows[i].resume;
      exp_q.push_back({rows[i].exp_halt, rows[i].exp_id});
      cyc();
      cpu_fetch = 1'b0; resume_in = 1'b0;
      e = exp_q.pop_front();
      n_total++;
      if ({halt_req, hit_id} !== e)
        $display("FAIL basic_halt[%0d]: halt/id got %b/%0d expected %b/%0d", i, halt_req, hit_id, e[2], e[1:0]);
      else n_pass++;
    end
  endtask

  task automatic test_resume_skip();
    row_t rows[$];
    logic [2:0] e;
    rows.push_back('{0, 16'h0000, 1, 0, 2'd2});
    rows.push_back('{1, 16'h1234, 0, 0, 2'd2});
    rows.push_back('{1, 16'h1234, 0, 1, 2'd2});
    rows.push_back('{1, 16'h1234, 1, 0, 2'd2});
    rows.push_back('{1, 16'h1234, 0, 0, 2'd2});
    rows.push_back('{0, 16'h0000, 1, 0, 2'd2});
    rows.push_back('{1, 16'h1234, 0, 1, 2'd2});
    foreach (rows[i]) begin
      cpu_fetch = rows[i].fetch; cpu_addr = rows[i].addr; resume_in = rows[i].resume;
      exp_q.push_back({rows[i].exp_halt, rows[i].exp_id});
      cyc();
      cpu_fetch = 1'b0; resume_in = 1'b0;
      e = exp_q.pop_front();
      n_total++;
      if ({halt_req, hit_id} !== e)
        $display("FAIL resume_skip[%0d]: halt/id got %b/%0d expected %b/%0d", i, halt_req, hit_id, e[2], e[1:0]);
      else n_pass++;
    end
    cfg_tog(2'd2);
    n_total++;
    if (halt_req !== 1'b1 || bp_enable !== 4'b0000)
      $display("FAIL halt_after_disable: halt/en got %b/%b expected 1/0000", halt_req, bp_enable);
    else n_pass++;
    cfg_wr(2'd2, 8'h00);
    n_total++;
    if (halt_req !== 1'b1 || cfg_disp !== 8'h00)
      $display("FAIL halt_after_rewrite: halt/disp got %b/%h expected 1/00", halt_req, cfg_disp);
    else n_pass++;
    cfg_wr(2'd2, 8'h34);
    cfg_tog(2'd2);
    rows.delete();
    rows.push_back('{0, 16'h0000, 1, 0, 2'd2});
    rows.push_back('{1, 16'h0000, 0, 0, 2'd2});
    rows.push_back('{1, 16'h1234, 0, 1, 2'd2});
    rows.push_back('{0, 16'h0000, 1, 0, 2'd2});
    rows.push_back('{1, 16'h0000, 0, 0, 2'd2});
    foreach (rows[i]) begin
      cpu_fetch = rows[i].fetch; cpu_addr = rows[i].addr; resume_in = rows[i].resume;
      exp_q.push_back({rows[i].exp_halt, rows[i].exp_id});
      cyc();
      cpu_fetch = 1'b0; resume_in = 1'b0;
      e = exp_q.pop_front();
      n_total++;
      if ({halt_req, hit_id} !== e)
        $display("FAIL restore[%0d]: halt/id got %b/%0d expected %b/%0d", i, halt_req, hit_id, e[2], e[1:0]);
      else n_pass++;
    end
  endtask

  task automatic test_priority();
    row_t rows[$];
    logic [2:0] e;
    cfg_wr(2'd1, 8'h00); cfg_next(); cfg_wr(2'd1, 8'h01); cfg_next();
    cfg_wr(2'd3, 8'h00); cfg_next(); cfg_wr(2'd3, 8'h01); cfg_next();
    cfg_tog(2'd3);
    n_total++;
    if (bp_enable !== 4'b1100) $display("FAIL prio_enable: got %b expected 1100", bp_enable); else n_pass++;
    rows.push_back('{1, 16'h0100, 0, 1, 2'd3});
    foreach (rows[i]) begin
      cpu_fetch = rows[i].fetch; cpu_addr = rows[i].addr; resume_in = rows[i].resume;
      exp_q.push_back({rows[i].exp_halt, rows[i].exp_id});
      cyc();
      cpu_fetch = 1'b0; resume_in = 1'b0;
      e = exp_q.pop_front();
      n_total++;
      if ({halt_req, hit_id} !== e)
        $display("FAIL prio_disabled[%0d]: halt/id got %b/%0d expected %b/%0d", i, halt_req, hit_id, e[2], e[1:0]);
      else n_pass++;
    end
    cfg_tog(2'd1);
    rows.delete();
    rows.push_back('{0, 16'h0000, 1, 0, 2'd3});
    rows.push_back('{1, 16'h0100, 0, 0, 2'd3});
    rows.push_back('{1, 16'h0100, 0, 1, 2'd1});
    rows.push_back('{0, 16'h0000, 1, 0, 2'd1});
    rows.push_back('{1, 16'h0000, 0, 0, 2'd1});
    foreach (rows[i]) begin
      cpu_fetch = rows[i].fetch; cpu_addr = rows[i].addr; resume_in = rows[i].resume;
      exp_q.push_back({rows[i].exp_halt, rows[i].exp_id});
      cyc();
      cpu_fetch = 1'b0; resume_in = 1'b0;
      e = exp_q.pop_front();
      n_total++;
      if ({halt_req, hit_id} !== e)
        $display("FAIL prio_lowest[%0d]: halt/id got %b/%0d expected %b/%0d", i, halt_req, hit_id, e[2], e[1:0]);
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    cfg_sel_in = 2'd0; cfg_part_in = 8'hAB;
    cfg_write_in = 1'b1; cfg_byte_next_in = 1'b1; cfg_en_toggle_in = 1'b1;
    cyc();
    cfg_write_in = 1'b0; cfg_byte_next_in = 1'b0; cfg_en_toggle_in = 1'b0;
    n_total++;
    if (cfg_byte_ptr !== 1'b1) $display("FAIL simul_ptr: got %0d expected 1", cfg_byte_ptr); else n_pass++;
    n_total++;
    if (bp_enable !== 4'b1111) $display("FAIL simul_enable: got %b expected 1111", bp_enable); else n_pass++;
    n_total++;
    if (cfg_disp !== 8'hFF) $display("FAIL simul_hi_kept: got %h expected ff", cfg_disp); else n_pass++;
    cfg_next();
    n_total++;
    if (cfg_disp !== 8'hAB) $display("FAIL simul_lo_written: got %h expected ab", cfg_disp); else n_pass++;
  endtask

  task automatic test_out_of_range();
    c3_sel = 2'd3; c3_part = 8'h55; c3_write = 1'b1; c3_toggle = 1'b1;
    cyc();
    c3_write = 1'b0; c3_toggle = 1'b0;
    n_total++;
    if (c3_disp !== 8'h00) $display("FAIL oor_disp: got %h expected 00", c3_disp); else n_pass++;
    n_total++;
    if (c3_enable !== 3'b000) $display("FAIL oor_enable: got %b expected 000", c3_enable); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      c3_sel = 2'(i);
      #1;
      n_total++;
      if (c3_disp !== 8'hFF) $display("FAIL oor_ch%0d_unchanged: got %h expected ff", i, c3_disp); else n_pass++;
    end
    c3_sel = 2'd2; c3_write = 1'b1; c3_toggle = 1'b1;
    cyc();
    c3_write = 1'b0; c3_toggle = 1'b0;
    n_total++;
    if (c3_disp !== 8'h55 || c3_enable !== 3'b100)
      $display("FAIL inrange_ch2: disp/en got %h/%b expected 55/100", c3_disp, c3_enable);
    else n_pass++;
  endtask

  task automatic test_reset_mid_halt();
    row_t rows[$];
    logic [2:0] e;
    rows.push_back('{1, 16'hFFAB, 0, 1, 2'd0});
    foreach (rows[i]) begin
      cpu_fetch = rows[i].fetch; cpu_addr = rows[i].addr; resume_in = rows[i].resume;
      exp_q.push_back({rows[i].exp_halt, rows[i].exp_id});
      cyc();
      cpu_fetch = 1'b0; resume_in = 1'b0;
      e = exp_q.pop_front();
      n_total++;
      if ({halt_req, hit_id} !== e)
        $display("FAIL pre_reset_halt[%0d]: halt/id got %b/%0d expected %b/%0d", i, halt_req, hit_id, e[2], e[1:0]);
      else n_pass++;
    end
    cfg_next();
    cfg_sel_in = 2'd2;
    #1 reset_n = 1'b0;
    #1;
    n_total++;
    if (halt_req !== 1'b0 || hit_id !== 2'd0)
      $display("FAIL midreset_halt: halt/id got %b/%0d expected 0/0", halt_req, hit_id);
    else n_pass++;
    n_total++;
    if (bp_enable !== 4'b0000) $display("FAIL midreset_enable: got %b expected 0000", bp_enable); else n_pass++;
    n_total++;
    if (cfg_byte_ptr !== 1'b0 || cfg_disp !== 8'hFF)
      $display("FAIL midreset_cfg: ptr/disp got %0d/%h expected 0/ff", cfg_byte_ptr, cfg_disp);
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    cyc();
    cfg_tog(2'd2);
    rows.delete();
    rows.push_back('{1, 16'h1234, 0, 0, 2'd0});
    rows.push_back('{1, 16'hFFFF, 0, 1, 2'd2});
    foreach (rows[i]) begin
      cpu_fetch = rows[i].fetch; cpu_addr = rows[i].addr; resume_in = rows[i].resume;
      exp_q.push_back({rows[i].exp_halt, rows[i].exp_id});
      cyc();
      cpu_fetch = 1'b0; resume_in = 1'b0;
      e = exp_q.pop_front();
      n_total++;
      if ({halt_req, hit_id} !== e)
        $display("FAIL post_reset[%0d]: halt/id got %b/%0d expected %b/%0d", i, halt_req, hit_id, e[2], e[1:0]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_byte_entry();
    test_basic_halt();
    test_resume_skip();
    test_priority();
    test_simultaneous();
    test_out_of_range();
    test_reset_mid_halt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
